// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared types and constants for the BCD two-digit joiner
package digit_pkg;

  localparam int BCD_MAX = 9;
  localparam int DIGIT_W = 4;
  localparam int NUM_W   = 7;

  typedef enum logic {
    IDLE      = 1'b0,
    HAVE_TENS = 1'b1
  } state_t;

  // tens*10 as two shifts so no multiplier is inferred; max 9*10 = 90 fits NUM_W
  function automatic logic [NUM_W-1:0] times_ten(input logic [DIGIT_W-1:0] tens);
    logic [NUM_W-1:0] t;
    t = {{(NUM_W-DIGIT_W){1'b0}}, tens};
    return (t << 3) + (t << 1);
  endfunction

endpackage

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - counts cycles while a tens digit waits for its ones digit
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // expired is asserted during the cycle whose closing edge would be the TIMEOUT_CYCLES-th
  assign expired = run && !restart && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || restart || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_join.sv
// rtl/digit_join.sv - joins two BCD digits into a binary 0..99 value
// Optional entry timeout enabled by defining DIGIT_JOIN_TIMEOUT_EN.
module digit_join
  import digit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               clear,
  output logic [NUM_W-1:0]   whole_num,
  output logic               num_valid,
  output logic               busy,
  output logic               err
);

  state_t             state;
  logic [DIGIT_W-1:0] tens;
  logic               digit_ok;
  logic               expired;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("digit_join: TIMEOUT_CYCLES must be at least 1");
  end

  assign digit_ok = digit_valid && (digit_in <= DIGIT_W'(BCD_MAX));
  assign busy     = (state == HAVE_TENS);

`ifdef DIGIT_JOIN_TIMEOUT_EN
  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_entry_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .restart (digit_ok || clear),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tens      <= '0;
      whole_num <= '0;
      num_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      err       <= 1'b0;
      // clear outranks any digit presented in the same cycle
      if (clear) begin
        state <= IDLE;
        tens  <= '0;
      end else if (digit_ok) begin
        if (state == IDLE) begin
          tens  <= digit_in;
          state <= HAVE_TENS;
        end else begin
          whole_num <= times_ten(tens) + NUM_W'(digit_in);
          num_valid <= 1'b1;
          tens      <= '0;
          state     <= IDLE;
        end
      end else begin
        if (digit_valid) err <= 1'b1;
        if (expired) begin
          whole_num <= NUM_W'(tens);
          num_valid <= 1'b1;
          tens      <= '0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_join.sv
// tb/tb_digit_join.sv - directed scoreboard bench for digit_join
module tb_digit_join;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] whole_num;
  logic       num_valid;
  logic       busy;
  logic       err;

  int         checks = 0;
  int         failures = 0;
  logic [6:0] sb[$];
  logic       prev_nv = 1'b0;

  always #5 clk = ~clk;

  digit_join #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .clear       (clear),
    .whole_num   (whole_num),
    .num_valid   (num_valid),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock with the given inputs; outputs sampled 1ns after the edge
  task automatic step(input logic dv, input logic [3:0] d, input logic clr, input logic exp_nv);
    logic [6:0] e;
    digit_valid = dv;
    digit_in    = d;
    clear       = clr;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    clear       = 1'b0;
    chk("num_valid", num_valid, exp_nv);
    chk("nv_single", prev_nv & num_valid, 0);
    prev_nv = num_valid;
    if (num_valid) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      chk("whole_num", whole_num, e);
    end
  endtask

  task automatic pair(input logic [3:0] a, input logic [3:0] b);
    step(1'b1, a, 1'b0, 1'b0);
    chk("busy_after_tens", busy, 1);
    sb.push_back(7'(a * 10 + b));
    step(1'b1, b, 1'b0, 1'b1);
    chk("busy_after_ones", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_whole_num", whole_num, 0);
    chk("rst_num_valid", num_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // 4 then 7, with an idle cycle between to confirm busy holds
    step(1'b1, 4'd4, 1'b0, 1'b0);
    chk("busy_47", busy, 1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("busy_47_hold", busy, 1);
    sb.push_back(7'd47);
    step(1'b1, 4'd7, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("hold_47", whole_num, 47);

    // boundaries, back-to-back with digit_valid held high
    pair(4'd0, 4'd0);
    pair(4'd9, 4'd9);
    pair(4'd1, 4'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // invalid digit in IDLE
    step(1'b1, 4'd12, 1'b0, 1'b0);
    chk("err_idle", err, 1);
    chk("busy_err_idle", busy, 0);
    chk("hold_after_err", whole_num, 10);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("err_pulse", err, 0);
    pair(4'd3, 4'd5);

    // invalid digit while holding tens keeps the tens digit
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd15, 1'b0, 1'b0);
    chk("err_tens", err, 1);
    chk("busy_err_tens", busy, 1);
    sb.push_back(7'd36);
    step(1'b1, 4'd6, 1'b0, 1'b1);

    // clear wins over a simultaneous digit
    step(1'b1, 4'd6, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b1, 1'b0);
    chk("busy_clear", busy, 0);
    chk("hold_clear", whole_num, 36);
    pair(4'd2, 4'd1);

    // entry timeout
    step(1'b1, 4'd8, 1'b0, 1'b0);
`ifdef DIGIT_JOIN_TIMEOUT_EN
    sb.push_back(7'd8);
    for (int i = 1; i <= 16; i++) step(1'b0, 4'd0, 1'b0, (i == 16));
    chk("busy_timeout", busy, 0);
`else
    for (int i = 1; i <= 16; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("busy_no_timeout", busy, 1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("busy_cleared", busy, 0);
`endif

    // asynchronous reset mid-entry
    step(1'b1, 4'd5, 1'b0, 1'b0);
    chk("busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_whole_num", whole_num, 0);
    chk("arst_busy", busy, 0);
    chk("arst_num_valid", num_valid, 0);
    chk("arst_err", err, 0);
    #1;
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0);
    pair(4'd1, 4'd2);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
